// File: rtl/memory_access_unit_pkg.sv
// Shared encodings for the memory access unit: store-size selects, fault codes, FSM states.
package memory_access_unit_pkg;

  // Store-size selects as produced by the store generator; loads use StoreSw.
  localparam logic [2:0] StoreSb = 3'b000;
  localparam logic [2:0] StoreSh = 3'b001;
  localparam logic [2:0] StoreSw = 3'b010;

  // Fault codes reported alongside O_done.
  localparam logic [1:0] FaultNone     = 2'b00;
  localparam logic [1:0] FaultMisalign = 2'b01;
  localparam logic [1:0] FaultBus      = 2'b10;
  localparam logic [1:0] FaultTimeout  = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } mau_state_e;

endpackage

// File: rtl/memory_access_unit_byte_enable_generator.sv
// Byte-lane enables and alignment check for a single load/store access.
module byte_enable_generator
  import memory_access_unit_pkg::*;
(
  input  logic [2:0] I_storesel,
  input  logic [1:0] I_addr,
  output logic [3:0] O_sel,
  output logic       O_misaligned
);

  // Decode access size into lane enables; unknown selects behave as a full word.
  always_comb begin
    O_sel        = 4'b1111;
    O_misaligned = (I_addr != 2'b00);
    case (I_storesel)
      StoreSb: begin
        O_sel        = 4'b0001 << I_addr;
        O_misaligned = 1'b0;
      end
      StoreSh: begin
        O_sel        = 4'b0011 << {I_addr[1], 1'b0};
        O_misaligned = I_addr[0];
      end
      default: begin
        O_sel        = 4'b1111;
        O_misaligned = (I_addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Single-beat cyc/stb/ack bus master for pipeline loads and stores, with fault reporting.
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [2:0]  I_storesel,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_data,
  output logic        O_busy,
  output logic        O_done,
  output logic [31:0] O_rdata,
  output logic        O_fault,
  output logic [1:0]  O_fault_code,
  output logic        O_bus_cyc,
  output logic        O_bus_stb,
  output logic        O_bus_we,
  output logic [31:0] O_bus_adr,
  output logic [3:0]  O_bus_sel,
  output logic [31:0] O_bus_dat,
  input  logic        I_bus_ack,
  input  logic        I_bus_err,
  input  logic [31:0] I_bus_dat
);

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  mau_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] dat_q, dat_d;

  logic [3:0]  req_sel;
  logic        req_misaligned;

  byte_enable_generator u_byte_enable_generator (
    .I_storesel   (I_storesel),
    .I_addr       (I_addr[1:0]),
    .O_sel        (req_sel),
    .O_misaligned (req_misaligned)
  );

  // Next-state: accept in IDLE, resolve err > ack > timeout in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    code_d  = FaultNone;
    rdata_d = rdata_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    dat_d   = dat_q;
    unique case (state_q)
      StIdle: begin
        // done_q masks the request still held by upstream during the done cycle.
        if (I_req && !done_q) begin
          if (req_misaligned) begin
            done_d  = 1'b1;
            fault_d = 1'b1;
            code_d  = FaultMisalign;
          end else begin
            adr_d   = {I_addr[31:2], 2'b00};
            sel_d   = req_sel;
            we_d    = I_we;
            dat_d   = I_data;
            cnt_d   = '0;
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (I_bus_err) begin
          state_d = StIdle;
          done_d  = 1'b1;
          fault_d = 1'b1;
          code_d  = FaultBus;
        end else if (I_bus_ack) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (!we_q) rdata_d = I_bus_dat;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
          fault_d = 1'b1;
          code_d  = FaultTimeout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FaultNone;
      rdata_q <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      rdata_q <= rdata_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
    end
  end

  assign O_busy       = (state_q != StIdle);
  assign O_done       = done_q;
  assign O_fault      = fault_q;
  assign O_fault_code = code_q;
  assign O_rdata      = rdata_q;
  assign O_bus_cyc    = (state_q == StAccess);
  assign O_bus_stb    = (state_q == StAccess);
  assign O_bus_we     = we_q;
  assign O_bus_adr    = adr_q;
  assign O_bus_sel    = sel_q;
  assign O_bus_dat    = dat_q;

endmodule
